// File: rtl/event_encoder_pkg.sv
// Shared definitions for the event encoder: default line count, index width
// helper and the default index type.
package event_encoder_pkg;

  // Default number of request lines.
  localparam int unsigned N_DEFAULT = 4;

  // Width of a binary index that selects one of n lines.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Index type for the default configuration.
  typedef logic [idx_w(N_DEFAULT)-1:0] idx_t;

endpackage : event_encoder_pkg

// File: rtl/event_encoder_prio_sel.sv
// prio_sel: combinational fixed-priority selector, highest set index wins.
//   vec_i      : candidate vector
//   any_c_o    : at least one candidate is set
//   idx_c_o    : binary index of the winning candidate (0 when none)
//   onehot_c_o : one-hot mask of the winning candidate (0 when none)
module prio_sel
  import event_encoder_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0]        vec_i,
  output logic                any_c_o,
  output logic [idx_w(N)-1:0] idx_c_o,
  output logic [N-1:0]        onehot_c_o
);

  localparam int unsigned W = idx_w(N);

  // Ascending scan: a later (higher) set bit overrides any earlier winner.
  always_comb begin
    any_c_o    = |vec_i;
    idx_c_o    = '0;
    onehot_c_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        idx_c_o    = W'(i);
        onehot_c_o = '0;
        onehot_c_o[i] = 1'b1;
      end
    end
  end

endmodule : prio_sel

// File: rtl/event_encoder.sv
// event_encoder: accumulates per-line event pulses into a pending register and
// presents the index of the highest-priority eligible event on a registered
// valid/ready output.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_i        : per-line event pulses (several may be high at once)
//   mask_i       : 1 = line eligible for selection (pending still accumulates)
//   ready_i      : consumer accepts code_o this cycle
//   clear_ovf_i  : clears the sticky overflow flags
//   valid_o      : code_o holds an unconsumed event
//   code_o       : binary index of the presented event
//   pending_o    : pending event register
//   overflow_o   : sticky per-line lost-event flags
module event_encoder
  import event_encoder_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_i,
  input  logic [N-1:0]        mask_i,
  input  logic                ready_i,
  input  logic                clear_ovf_i,
  output logic                valid_o,
  output logic [idx_w(N)-1:0] code_o,
  output logic [N-1:0]        pending_o,
  output logic [N-1:0]        overflow_o
);

  localparam int unsigned W = idx_w(N);

  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;

  logic [N-1:0] cand;
  logic         sel_any;
  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_onehot;
  logic         load;
  logic [N-1:0] consume;

  assign cand = (pending_q | req_i) & mask_i;

  prio_sel #(.N(N)) u_prio_sel (
    .vec_i      (cand),
    .any_c_o    (sel_any),
    .idx_c_o    (sel_idx),
    .onehot_c_o (sel_onehot)
  );

  // Output stage may take a new event when empty or being drained.
  assign load    = ~valid_q | ready_i;
  assign consume = (load & sel_any) ? sel_onehot : '0;

  // Next-state for output stage, pending register and overflow flags.
  always_comb begin
    valid_d   = valid_q;
    code_d    = code_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;

    if (load) begin
      valid_d = sel_any;
      if (sel_any) begin
        code_d = sel_idx;
      end
    end

    // On a consumed line the pending event goes first; a same-cycle request
    // on that line is then retained as the new pending event. If nothing was
    // pending, the request itself is the consumed event.
    pending_d = ((pending_q | req_i) & ~consume) | (pending_q & req_i);

    // A second event on a full, unconsumed line is lost; set beats clear.
    ovf_d = (clear_ovf_i ? '0 : ovf_q) | (req_i & pending_q & ~consume);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      code_q    <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign code_o     = code_q;
  assign pending_o  = pending_q;
  assign overflow_o = ovf_q;

endmodule : event_encoder
